// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic-array sequencer and its array.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COLLECT = 2'd2,
    ST_READ    = 2'd3
  } seq_state_t;

  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_OUT_W = 64;
  localparam int unsigned DEF_DEPTH = 8;

  function automatic int unsigned calc_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/seq_buf.sv
// DEPTH x W buffer: synchronous write, registered read port.
module seq_buf
  import systolic_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_DEPTH,
  parameter  int unsigned W     = 32,
  localparam int unsigned AW    = calc_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/systolic_seq.sv
// Sequencer: buffers input rows, streams them to the array, collects results, serves reads.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int unsigned LANES   = DEF_LANES,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned OUT_W   = DEF_OUT_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  input  logic [LANES*DW-1:0] wr_data,
  output logic                wr_ready,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                rd_req,
  output logic                rd_valid,
  output logic [OUT_W-1:0]    rd_data,
  output logic                rd_last,
  output logic                arr_en,
  output logic [LANES*DW-1:0] arr_a,
  input  logic [OUT_W-1:0]    arr_out,
  input  logic                arr_out_valid
);

  localparam int unsigned IW = LANES * DW;
  localparam int unsigned AW = calc_aw(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  seq_state_t    state, state_nx;
  logic [PW-1:0] wr_ptr, wr_ptr_nx, len, len_nx, out_cnt, out_cnt_nx, rd_ptr, rd_ptr_nx;
  logic [PW-1:0] rd_ptr_inc, eff_cnt;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic          err_nx, done_nx, rd_valid_nx, rd_last_nx, arr_en_nx;
  logic          wr_acc, ib_we, ib_re, ob_we, ob_re;

  assign wr_ready   = (state == ST_IDLE) && (wr_ptr != PW'(DEPTH));
  assign busy       = (state != ST_IDLE);
  assign wr_acc     = wr_valid && wr_ready && !abort;
  assign eff_cnt    = wr_ptr + PW'(wr_acc);
  assign rd_ptr_inc = rd_ptr + PW'(1);

  seq_buf #(.DEPTH(DEPTH), .W(IW)) u_ibuf (
    .clk(clk), .rst(rst),
    .we(ib_we), .waddr(wr_ptr[AW-1:0]), .wdata(wr_data),
    .re(ib_re), .raddr(rd_ptr[AW-1:0]), .rdata(arr_a)
  );

  seq_buf #(.DEPTH(DEPTH), .W(OUT_W)) u_obuf (
    .clk(clk), .rst(rst),
    .we(ob_we), .waddr(out_cnt[AW-1:0]), .wdata(arr_out),
    .re(ob_re), .raddr(rd_ptr[AW-1:0]), .rdata(rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      len      <= '0;
      out_cnt  <= '0;
      rd_ptr   <= '0;
      tmo_cnt  <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      arr_en   <= 1'b0;
    end else begin
      state    <= state_nx;
      wr_ptr   <= wr_ptr_nx;
      len      <= len_nx;
      out_cnt  <= out_cnt_nx;
      rd_ptr   <= rd_ptr_nx;
      tmo_cnt  <= tmo_nx;
      err      <= err_nx;
      done     <= done_nx;
      rd_valid <= rd_valid_nx;
      rd_last  <= rd_last_nx;
      arr_en   <= arr_en_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wr_ptr_nx   = wr_ptr;
    len_nx      = len;
    out_cnt_nx  = out_cnt;
    rd_ptr_nx   = rd_ptr;
    tmo_nx      = tmo_cnt;
    err_nx      = err;
    done_nx     = 1'b0;
    rd_valid_nx = 1'b0;
    rd_last_nx  = 1'b0;
    arr_en_nx   = 1'b0;
    ib_we       = 1'b0;
    ib_re       = 1'b0;
    ob_we       = 1'b0;
    ob_re       = 1'b0;

    // Results are only expected while a run is in flight; anything else is an error.
    if (arr_out_valid) begin
      if ((state == ST_RUN || state == ST_COLLECT) && (out_cnt < len)) begin
        ob_we      = 1'b1;
        out_cnt_nx = out_cnt + PW'(1);
      end else begin
        err_nx = 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (wr_acc) begin
          ib_we     = 1'b1;
          wr_ptr_nx = wr_ptr + PW'(1);
        end
        if (start && (eff_cnt != '0)) begin
          len_nx     = eff_cnt;
          err_nx     = 1'b0;
          rd_ptr_nx  = '0;
          out_cnt_nx = '0;
          state_nx   = ST_RUN;
        end
      end
      ST_RUN: begin
        ib_re     = 1'b1;
        arr_en_nx = 1'b1;
        rd_ptr_nx = rd_ptr_inc;
        tmo_nx    = '0;
        if (rd_ptr_inc == len) begin
          rd_ptr_nx = '0;
          state_nx  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (out_cnt == len) begin
          done_nx  = 1'b1;
          state_nx = ST_READ;
        end else if (arr_out_valid) begin
          tmo_nx = '0;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          done_nx  = 1'b1;
          state_nx = ST_READ;
        end else begin
          tmo_nx = tmo_cnt + TW'(1);
        end
      end
      ST_READ: begin
        if (rd_last || (out_cnt == '0)) begin
          wr_ptr_nx = '0;
          state_nx  = ST_IDLE;
        end else if (rd_req && (rd_ptr < out_cnt)) begin
          ob_re       = 1'b1;
          rd_valid_nx = 1'b1;
          rd_last_nx  = (rd_ptr_inc == out_cnt);
          rd_ptr_nx   = rd_ptr_inc;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // Abort wins over everything; the error flag survives it.
    if (abort) begin
      state_nx    = ST_IDLE;
      wr_ptr_nx   = '0;
      rd_ptr_nx   = '0;
      out_cnt_nx  = '0;
      len_nx      = len;
      tmo_nx      = '0;
      err_nx      = err;
      done_nx     = 1'b0;
      rd_valid_nx = 1'b0;
      rd_last_nx  = 1'b0;
      arr_en_nx   = 1'b0;
      ib_we       = 1'b0;
      ib_re       = 1'b0;
      ob_we       = 1'b0;
      ob_re       = 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_seq.sv
// Scoreboard bench for systolic_seq with a 2-cycle model array.
module tb_systolic_seq;

  localparam int unsigned LANES   = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned OUT_W   = 64;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned IW      = LANES * DW;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_valid, start, abort, rd_req;
  logic [IW-1:0]    wr_data;
  logic             wr_ready, busy, done, err, rd_valid, rd_last, arr_en;
  logic [OUT_W-1:0] rd_data;
  logic [IW-1:0]    arr_a;
  logic [OUT_W-1:0] arr_out;
  logic             arr_out_valid;

  always #5 clk = ~clk;

  systolic_seq #(
    .LANES(LANES), .DW(DW), .OUT_W(OUT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .arr_en(arr_en), .arr_a(arr_a), .arr_out(arr_out), .arr_out_valid(arr_out_valid)
  );

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } rd_exp_t;

  logic [IW-1:0] exp_arr_q [$];
  rd_exp_t       exp_rd_q  [$];
  logic [IW-1:0] rows_q    [$];
  rd_exp_t       rd_e;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int arr_en_cnt = 0;
  int done_cnt = 0;
  int last_valid_cyc = 0;
  int arr_keep = 0;
  int arr_sent;

  logic             p1v, p2v;
  logic [OUT_W-1:0] p1d, p2d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model array: returns arr_a zero-extended, 2 cycles after arr_en, up to arr_keep results per run.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1v <= 1'b0; p2v <= 1'b0; p1d <= '0; p2d <= '0; arr_sent <= 0;
    end else begin
      p1v <= 1'b0;
      if (start && !busy) arr_sent <= 0;
      else if (arr_en && arr_sent < arr_keep) begin
        p1v      <= 1'b1;
        p1d      <= OUT_W'(arr_a);
        arr_sent <= arr_sent + 1;
      end
      p2v <= p1v;
      p2d <= p1d;
    end
  end
  assign arr_out       = p2d;
  assign arr_out_valid = p2v;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every presented array row and read result against the scoreboard.
  always @(negedge clk) begin
    if (!rst && arr_en) begin
      arr_en_cnt++;
      if (exp_arr_q.size() == 0) check("arr_a_unexpected", 64'(1), 64'(0));
      else check("arr_a", 64'(arr_a), 64'(exp_arr_q.pop_front()));
    end
    if (!rst && rd_valid) begin
      if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
      else begin
        rd_e = exp_rd_q.pop_front();
        check("rd_data", rd_data, rd_e.data);
        check("rd_last", 64'(rd_last), 64'(rd_e.last));
      end
    end
    if (!rst && done) done_cnt++;
    if (!rst && arr_out_valid) last_valid_cyc = cyc;
  end

  task automatic write_row(input logic [IW-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    rows_q.push_back(d);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic prep_exp(input int keep);
    for (int i = 0; i < rows_q.size(); i++) begin
      exp_arr_q.push_back(rows_q[i]);
      if (i < keep) exp_rd_q.push_back('{data: OUT_W'(rows_q[i]), last: 1'(i == keep - 1)});
    end
    rows_q.delete();
    arr_keep = keep;
  endtask

  task automatic finish_run(input int n_rows, input int keep, input logic exp_err,
                            input int a0, input int d0);
    int w = 0;
    while (!done && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", 64'(done), 64'(1));
    check("err_at_done", 64'(err), 64'(exp_err));
    check("arr_en_cycles", 64'(arr_en_cnt - a0), 64'(n_rows));
    if (keep < n_rows) check("timeout_gap", 64'(cyc - last_valid_cyc), 64'(TIMEOUT + 1));
    @(negedge clk);
    check("done_pulse_width", 64'(done), 64'(0));
    rd_req = 1'b1;
    for (int i = 0; i < keep; i++) @(negedge clk);
    rd_req = 1'b0;
    check("rd_last_final", 64'(rd_last), 64'(1));
    @(negedge clk);
    check("busy_after_read", 64'(busy), 64'(0));
    check("done_count", 64'(done_cnt - d0), 64'(1));
    check("rd_q_empty", 64'(exp_rd_q.size()), 64'(0));
    check("arr_q_empty", 64'(exp_arr_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a0, d0;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; start = 1'b0; abort = 1'b0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wr_ready", 64'(wr_ready), 64'(1));
    check("rst_arr_en", 64'(arr_en), 64'(0));
    check("rst_arr_a", 64'(arr_a), 64'(0));
    check("rst_rd_data", rd_data, 64'(0));
    check("rst_err", 64'(err), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Start with nothing buffered is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("empty_start_busy", 64'(busy), 64'(0));
      check("empty_start_arr_en", 64'(arr_en), 64'(0));
      @(negedge clk);
    end

    // Basic 3-row run.
    a0 = arr_en_cnt; d0 = done_cnt;
    write_row(32'h01020304);
    write_row(32'h05060708);
    write_row(32'h090A0B0C);
    prep_exp(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("basic_busy", 64'(busy), 64'(1));
    finish_run(3, 3, 1'b0, a0, d0);

    // Full buffer: 9 rows offered with wr_valid held, only 8 taken.
    a0 = arr_en_cnt; d0 = done_cnt;
    for (int k = 0; k < 9; k++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hA000_0000 + 32'(k * 32'h0101);
      check("full_wr_ready", 64'(wr_ready), 64'(k < 8));
      if (k < 8) rows_q.push_back(wr_data);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("full_wr_ready_after", 64'(wr_ready), 64'(0));
    prep_exp(8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_run(8, 8, 1'b0, a0, d0);

    // Third row written in the same cycle as start is part of the run.
    a0 = arr_en_cnt; d0 = done_cnt;
    write_row(32'h11223344);
    write_row(32'h55667788);
    rows_q.push_back(32'h99AABBCC);
    prep_exp(3);
    wr_valid = 1'b1; wr_data = 32'h99AABBCC; start = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; start = 1'b0;
    finish_run(3, 3, 1'b0, a0, d0);

    // Timeout: only one of two results returns.
    a0 = arr_en_cnt; d0 = done_cnt;
    write_row(32'hDEADBEEF);
    write_row(32'hCAFEF00D);
    prep_exp(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_run(2, 1, 1'b1, a0, d0);
    check("err_sticky", 64'(err), 64'(1));

    // Abort in the middle of RUN.
    for (int i = 0; i < 4; i++) write_row(32'h0F000000 + 32'(i));
    prep_exp(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_pre_arr_en", 64'(arr_en), 64'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_arr_en", 64'(arr_en), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_wr_ready", 64'(wr_ready), 64'(1));
    repeat (6) @(negedge clk);
    exp_arr_q.delete();
    exp_rd_q.delete();

    // Asynchronous reset while waiting in COLLECT.
    write_row(32'h12345678);
    write_row(32'h9ABCDEF0);
    prep_exp(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("collect_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_arr_en", 64'(arr_en), 64'(0));
    check("arst_arr_a", 64'(arr_a), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_err", 64'(err), 64'(0));
    check("arst_rd_valid", 64'(rd_valid), 64'(0));
    check("arst_rd_last", 64'(rd_last), 64'(0));
    check("arst_rd_data", rd_data, 64'(0));
    check("arst_wr_ready", 64'(wr_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    exp_arr_q.delete();
    exp_rd_q.delete();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
